alu_seq: RTL and testbench

- Parametrised, sequential successor to the 16-bit combinational ALU.
- Carry and zero flags live in an internal status register instead of arriving as inputs.
- Adds a valid/ready handshake and iterative multi-cycle ops: multiply, and shift-left by N.
- Sits between the register file/memory operand mux and writeback; pc_skip feeds the PC sequencer.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_iter_unit.sv | 110 +++++++++++
 rtl/alu_seq.sv | 197 +++++++++++++++++++
 tb/tb_alu_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states, default width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Optional feature macro used by this slice: ALU_MUL_EN (iterative multiply on op A).
package alu_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic [3:0] OP_ROTL  = 4'h0;
   localparam logic [3:0] OP_ROTR  = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_SUB   = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h4;
   localparam logic [3:0] OP_OR    = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_ZTST  = 4'h7;
   localparam logic [3:0] OP_PCZ   = 4'h8;
   localparam logic [3:0] OP_PCZB  = 4'h9;
   localparam logic [3:0] OP_MUL   = 4'hA;
   localparam logic [3:0] OP_SHLN  = 4'hB;
   localparam logic [3:0] OP_NOP   = 4'hC;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the operand mux, the ALU and writeback.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side; the response is a one-cycle out_valid pulse.
// Ports: master = requester (drives in_valid, alu_op, mem, wreg); slave = ALU (drives in_ready
//        and the registered result, carry_flag, zero_flag, pc_skip, out_valid).
interface alu_seq_if import alu_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] mem;
   logic [WIDTH-1:0] wreg;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic             carry_flag;
   logic             zero_flag;
   logic             pc_skip;

   modport master (
      output in_valid, alu_op, mem, wreg,
      input  in_ready, out_valid, result, carry_flag, zero_flag, pc_skip
   );

   modport slave (
      input  in_valid, alu_op, mem, wreg,
      output in_ready, out_valid, result, carry_flag, zero_flag, pc_skip
   );
endinterface

// File: rtl/alu_iter_unit.sv
// Iteration engine shared by ShlN (one bit per cycle) and, with ALU_MUL_EN, shift-add multiply.
// Latency: one step on the start edge plus one per busy cycle; done_o when the counter reaches 0.
// Backpressure: none; the caller holds step_en_i only while it is busy.
// Ports: start_i loads operands and performs the first step; step_en_i advances one step;
//        res_o/carry_o present the value the current edge will produce (the caller registers it).
// Macro ALU_MUL_EN: when undefined the multiplier state and adder are not built.
module alu_iter_unit import alu_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             step_en_i,
`ifdef ALU_MUL_EN
   input  logic             is_mul_i,
   input  logic [WIDTH-1:0] mcand_i,
`endif
   input  logic [WIDTH-1:0] lo_init_i,
   input  logic [CNT_W-2:0] n_i,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o,
   output logic             carry_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] src_lo;
   logic [WIDTH-1:0] lo_nxt;

`ifdef ALU_MUL_EN
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic             mul_q, mul_d;
   logic [WIDTH-1:0] src_hi, src_mcand, hi_nxt;
   logic             src_mul;
   logic [WIDTH:0]   sum;
`endif

   always_comb begin
      cnt_d  = cnt_q;
      lo_d   = lo_q;
      // On the start edge the step works directly on the incoming operands.
      src_lo = start_i ? lo_init_i : lo_q;
      lo_nxt = {src_lo[WIDTH-2:0], 1'b0};
      carry_o = src_lo[WIDTH-1];
`ifdef ALU_MUL_EN
      hi_d      = hi_q;
      mcand_d   = mcand_q;
      mul_d     = mul_q;
      src_hi    = start_i ? '0 : hi_q;
      src_mcand = start_i ? mcand_i : mcand_q;
      src_mul   = start_i ? is_mul_i : mul_q;
      // Right-shifting multiplier: {carry, hi, lo} >> 1 after conditionally adding mcand to hi.
      // After WIDTH steps {hi, lo} holds the full product.
      sum    = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mcand} : '0);
      hi_nxt = '0;
      if (src_mul) begin
         hi_nxt  = sum[WIDTH:1];
         lo_nxt  = {sum[0], src_lo[WIDTH-1:1]};
         carry_o = |sum[WIDTH:1];
      end
`endif
      res_o = lo_nxt;

      // Counter holds the number of busy cycles still to run after the current one.
      if (start_i) begin
         cnt_d = (n_i < (CNT_W-1)'(2)) ? '0 : ({1'b0, n_i} - CNT_W'(2));
`ifdef ALU_MUL_EN
         if (is_mul_i) begin
            cnt_d = CNT_W'(WIDTH - 2);
         end
`endif
      end else if (step_en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      if (start_i || step_en_i) begin
         lo_d = lo_nxt;
`ifdef ALU_MUL_EN
         hi_d    = hi_nxt;
         mcand_d = src_mcand;
         mul_d   = src_mul;
`endif
      end

      done_o = (cnt_q == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         lo_q  <= '0;
`ifdef ALU_MUL_EN
         hi_q    <= '0;
         mcand_q <= '0;
         mul_q   <= 1'b0;
`endif
      end else begin
         cnt_q <= cnt_d;
         lo_q  <= lo_d;
`ifdef ALU_MUL_EN
         hi_q    <= hi_d;
         mcand_q <= mcand_d;
         mul_q   <= mul_d;
`endif
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with internal carry/zero status, valid/ready input and one-cycle out_valid pulse.
// Latency: 1 cycle for single-cycle ops; WIDTH for Mul; max(1, n) for ShlN.
// Backpressure: in_ready=1 only in IDLE (and not in reset); requests are ignored while BUSY.
// Ports: clk, reset (sync, active-high); bus = alu_seq_if.slave carrying the request and the
//        registered result, carry_flag, zero_flag, pc_skip and out_valid.
// Macro ALU_MUL_EN: enables iterative multiply on op A; otherwise op A is a Nop.
module alu_seq import alu_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic      clk,
   input  logic      reset,
   alu_seq_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             skip_q, skip_d;
   logic             ovld_q, ovld_d;

   logic             accept;
   logic             upd_z;
   logic             iter_start;
   logic             iter_done;
   logic             iter_carry;
   logic [WIDTH-1:0] iter_res;
   logic [WIDTH-1:0] lo_init;
   logic [CNT_W-2:0] shl_n;
   logic [WIDTH:0]   arith;

   assign shl_n        = bus.wreg[CNT_W-2:0];
   assign bus.in_ready = (state_q == IDLE) && !reset;
   assign accept       = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_EN
   assign lo_init = (bus.alu_op == OP_MUL) ? bus.wreg : bus.mem;
`else
   assign lo_init = bus.mem;
`endif

   alu_iter_unit #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk       (clk),
      .reset     (reset),
      .start_i   (iter_start),
      .step_en_i (state_q == BUSY),
`ifdef ALU_MUL_EN
      .is_mul_i  (bus.alu_op == OP_MUL),
      .mcand_i   (bus.mem),
`endif
      .lo_init_i (lo_init),
      .n_i       (shl_n),
      .done_o    (iter_done),
      .res_o     (iter_res),
      .carry_o   (iter_carry)
   );

   always_comb begin
      state_d    = state_q;
      result_d   = result_q;
      carry_d    = carry_q;
      zero_d     = zero_q;
      skip_d     = 1'b0;
      ovld_d     = 1'b0;
      upd_z      = 1'b0;
      iter_start = 1'b0;
      arith      = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               ovld_d = 1'b1;
               case (bus.alu_op)
                  OP_ROTL: begin
                     result_d = {bus.mem[WIDTH-2:0], carry_q};
                     carry_d  = bus.mem[WIDTH-1];
                  end
                  OP_ROTR: begin
                     result_d = {carry_q, bus.mem[WIDTH-1:1]};
                     carry_d  = bus.mem[0];
                  end
                  OP_ADD: begin
                     arith    = {1'b0, bus.mem} + {1'b0, bus.wreg};
                     result_d = arith[WIDTH-1:0];
                     carry_d  = arith[WIDTH];
                     upd_z    = 1'b1;
                  end
                  OP_SUB: begin
                     // Carry out of mem + ~wreg + 1 is the "no borrow" flag.
                     arith    = {1'b0, bus.mem} + {1'b0, ~bus.wreg} + (WIDTH+1)'(1);
                     result_d = arith[WIDTH-1:0];
                     carry_d  = arith[WIDTH];
                     upd_z    = 1'b1;
                  end
                  OP_AND: begin
                     result_d = bus.mem & bus.wreg;
                     upd_z    = 1'b1;
                  end
                  OP_OR: begin
                     result_d = bus.mem | bus.wreg;
                     upd_z    = 1'b1;
                  end
                  OP_XOR: begin
                     result_d = bus.mem ^ bus.wreg;
                     upd_z    = 1'b1;
                  end
                  OP_ZTST: begin
                     result_d = bus.mem;
                     upd_z    = 1'b1;
                  end
                  OP_PCZ: begin
                     result_d = bus.mem;
                     skip_d   = |bus.mem;
                  end
                  OP_PCZB: begin
                     result_d = bus.mem;
                     skip_d   = ~|bus.mem;
                  end
`ifdef ALU_MUL_EN
                  OP_MUL: begin
                     iter_start = 1'b1;
                     ovld_d     = 1'b0;
                     state_d    = BUSY;
                  end
`endif
                  OP_SHLN: begin
                     upd_z = 1'b1;
                     if (shl_n == '0) begin
                        result_d = bus.mem;
                     end else if (shl_n == (CNT_W-1)'(1)) begin
                        // A single shift finishes on the start step itself.
                        iter_start = 1'b1;
                        result_d   = iter_res;
                        carry_d    = iter_carry;
                     end else begin
                        iter_start = 1'b1;
                        ovld_d     = 1'b0;
                        upd_z      = 1'b0;
                        state_d    = BUSY;
                     end
                  end
                  default: begin
                     result_d = bus.wreg;
                  end
               endcase
            end
         end
         BUSY: begin
            // Mul and ShlN both finish with result, carry and Z taken from the iteration unit.
            if (iter_done) begin
               result_d = iter_res;
               carry_d  = iter_carry;
               upd_z    = 1'b1;
               ovld_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (upd_z) begin
         zero_d = ~|result_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         skip_q   <= 1'b0;
         ovld_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         skip_q   <= skip_d;
         ovld_q   <= ovld_d;
      end
   end

   assign bus.out_valid  = ovld_q;
   assign bus.result     = result_q;
   assign bus.carry_flag = carry_q;
   assign bus.zero_flag  = zero_q;
   assign bus.pc_skip    = skip_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=16) plus hand-written multi-cycle sequences.
// Latency: n/a.
// Backpressure: drives in_valid and waits on in_ready/out_valid with bounded loops.
module tb_alu_seq;
   import alu_pkg::*;

   localparam int W = 16;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         c;
      logic         z;
      logic         s;
      int           lat;
   } vec_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   alu_seq_if #(.WIDTH(W)) bus ();

   alu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic c, input logic z,
                               input logic s, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.c = c; v.z = z; v.s = s; v.lat = lat;
      return v;
   endfunction

   // Issue one request from a negedge, scramble operands after accept, wait for the pulse.
   task automatic run_vec(input vec_t v, input int i);
      int lat;
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      bus.alu_op   = v.op;
      bus.mem      = v.a;
      bus.wreg     = v.b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.mem      = ~v.a;
      bus.wreg     = ~v.b;
      lat = 1;
      while (!bus.out_valid && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
      chk($sformatf("v%0d_result", i), 32'(bus.result), 32'(v.res));
      chk($sformatf("v%0d_carry", i), 32'(bus.carry_flag), 32'(v.c));
      chk($sformatf("v%0d_zero", i), 32'(bus.zero_flag), 32'(v.z));
      chk($sformatf("v%0d_pc_skip", i), 32'(bus.pc_skip), 32'(v.s));
      chk($sformatf("v%0d_ready_at_done", i), 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d_skip_end", i), 32'(bus.pc_skip), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      int   busy;
      int   early;

      total = 0;
      bad   = 0;
      clk   = 1'b0;
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.alu_op   = OP_NOP;
      bus.mem      = '0;
      bus.wreg     = '0;

      //                 op       mem      wreg     result   c     z     skip  lat
      vecs.push_back(mk(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1));
      vecs.push_back(mk(OP_SUB,  16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1));
      vecs.push_back(mk(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_SUB,  16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_ROTL, 16'h8000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_ROTR, 16'h0001, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_OR,   16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1));
      vecs.push_back(mk(OP_XOR,  16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_ZTST, 16'h0000, 16'h1111, 16'h0000, 1'b1, 1'b1, 1'b0, 1));
      vecs.push_back(mk(OP_SHLN, 16'h8001, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 3));
      vecs.push_back(mk(OP_PCZ,  16'h0004, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b1, 1));
      vecs.push_back(mk(OP_PCZB, 16'h0004, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_PCZB, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1));
      vecs.push_back(mk(OP_SHLN, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_SHLN, 16'hC000, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_SHLN, 16'h0001, 16'h0010, 16'h0001, 1'b1, 1'b0, 1'b0, 1));
      vecs.push_back(mk(OP_SHLN, 16'h8000, 16'h000F, 16'h0000, 1'b0, 1'b1, 1'b0, 15));
      vecs.push_back(mk(OP_NOP,  16'h1111, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk(4'hF,    16'h0000, 16'h0042, 16'h0042, 1'b0, 1'b1, 1'b0, 1));
`ifdef ALU_MUL_EN
      vecs.push_back(mk(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 16));
      vecs.push_back(mk(OP_MUL,  16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 16));
      vecs.push_back(mk(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16));
`else
      vecs.push_back(mk(OP_MUL,  16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk(OP_MUL,  16'h0003, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 1));
      vecs.push_back(mk(OP_MUL,  16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1));
`endif

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_carry", 32'(bus.carry_flag), 32'd0);
      chk("rst_zero", 32'(bus.zero_flag), 32'd0);
      chk("rst_pc_skip", 32'(bus.pc_skip), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release_ready", 32'(bus.in_ready), 32'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], i);
      end

      // Reset five cycles into a long op: no completion, everything cleared.
`ifdef ALU_MUL_EN
      bus.alu_op = OP_MUL;  bus.mem = 16'h0100; bus.wreg = 16'h0100;
`else
      bus.alu_op = OP_SHLN; bus.mem = 16'h8000; bus.wreg = 16'h000F;
`endif
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      early = 0;
      for (int k = 0; k < 4; k++) begin
         if (bus.out_valid) early++;
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready_in_reset", 32'(bus.in_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", 32'(bus.in_ready), 32'd1);
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_carry", 32'(bus.carry_flag), 32'd0);
      chk("abort_zero", 32'(bus.zero_flag), 32'd0);
      for (int k = 0; k < 20; k++) begin
         if (bus.out_valid) early++;
         @(negedge clk);
      end
      chk("abort_no_out_valid", 32'(early), 32'd0);

      // Back-to-back single-cycle ops with in_valid held high.
      bus.alu_op = OP_ADD; bus.mem = 16'h0001; bus.wreg = 16'h0002; bus.in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_first_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_first_result", 32'(bus.result), 32'h0003);
      chk("b2b_first_ready", 32'(bus.in_ready), 32'd1);
      bus.alu_op = OP_XOR; bus.mem = 16'h00FF; bus.wreg = 16'h0F0F;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("b2b_second_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_second_result", 32'(bus.result), 32'h0FF0);
      chk("b2b_second_zero", 32'(bus.zero_flag), 32'd0);
      @(negedge clk);

`ifdef ALU_MUL_EN
      // Request held during BUSY is taken only once in_ready returns.
      bus.alu_op = OP_MUL; bus.mem = 16'h0100; bus.wreg = 16'h0100; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.alu_op = OP_ADD; bus.mem = 16'h0001; bus.wreg = 16'h0002;
      busy  = 0;
      early = 0;
      while (!bus.in_ready && busy < 64) begin
         if (bus.out_valid) early++;
         busy++;
         @(negedge clk);
      end
      chk("hold_busy_cycles", 32'(busy), 32'd15);
      chk("hold_no_early_valid", 32'(early), 32'd0);
      chk("hold_mul_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_mul_result", 32'(bus.result), 32'h0000);
      chk("hold_mul_carry", 32'(bus.carry_flag), 32'd1);
      chk("hold_mul_zero", 32'(bus.zero_flag), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("hold_add_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_add_result", 32'(bus.result), 32'h0003);
      chk("hold_add_carry", 32'(bus.carry_flag), 32'd0);
      chk("hold_add_zero", 32'(bus.zero_flag), 32'd0);
      @(negedge clk);
      chk("hold_add_pulse_end", 32'(bus.out_valid), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
